// File: rtl/quant_writeback.sv
// quant_writeback: output writeback stage that sits after the quantizer.
// It buffers quantized rows in a 2-entry FIFO and turns each row into WORDS
// sequential SRAM writes of one word per cycle. It pulses done after NUM_ROWS
// rows of a tile have been written.
// Optional feature: when QWB_RELU_EN is defined, negative elements are written
// as 0 while the row is packed. The data held in the FIFO is left unchanged.
// Ports:
//   clk, srst           clock and synchronous active-high reset
//   start, cfg_base_addr  begin a tile and load its base address
//   in_valid/in_ready/in_data  row input handshake
//   sram_wen (low-active), sram_addr, sram_wdata  registered SRAM write port
//   busy, done          tile status
module quant_writeback #(
  parameter int unsigned ARRAY_SIZE        = 16,
  parameter int unsigned OUTPUT_DATA_WIDTH = 16,
  parameter int unsigned SRAM_DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned NUM_ROWS          = 16
) (
  input  logic                                      clk,
  input  logic                                      srst,
  input  logic                                      start,
  input  logic [ADDR_WIDTH-1:0]                     cfg_base_addr,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   in_data,
  output logic                                      sram_wen,
  output logic [ADDR_WIDTH-1:0]                     sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0]                sram_wdata,
  output logic                                      busy,
  output logic                                      done
);

  localparam int unsigned EPW   = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH;
  localparam int unsigned WORDS = ARRAY_SIZE / EPW;
  localparam int unsigned ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned RCW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [RCW-1:0]          row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ROW_W-1:0]        fifo_mem [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              fifo_cnt_q, fifo_cnt_d;

  logic                    push_c, pop_c, emit_c, start_take_c;
  logic                    busy_d, done_d, wen_d, in_ready_d;
  logic [ADDR_WIDTH-1:0]   addr_d, addr_c;
  logic [SRAM_DATA_WIDTH-1:0] wdata_d, pack_c;
  logic [31:0]             addr_sum_c;

  assign push_c = in_valid && in_ready;

  // Current word of the FIFO head row and its target address.
  always_comb begin
    pack_c     = '0;
    addr_sum_c = 32'(base_q) + 32'(row_cnt_q) * WORDS + 32'(word_cnt_q);
    addr_c     = addr_sum_c[ADDR_WIDTH-1:0];
    for (int unsigned k = 0; k < EPW; k++) begin
      logic [OUTPUT_DATA_WIDTH-1:0] elem;
      int unsigned                  bit_pos;
      bit_pos = (32'(word_cnt_q) * EPW + k) * OUTPUT_DATA_WIDTH;
      elem    = fifo_mem[rd_ptr_q][bit_pos +: OUTPUT_DATA_WIDTH];
`ifdef QWB_RELU_EN
      if (elem[OUTPUT_DATA_WIDTH-1]) elem = '0;
`endif
      pack_c[k*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = elem;
    end
  end

  // Next-state, counters, FIFO occupancy and registered-output values.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    row_cnt_d    = row_cnt_q;
    base_d       = base_q;
    fifo_cnt_d   = fifo_cnt_q;
    busy_d       = busy;
    done_d       = 1'b0;
    wen_d        = 1'b1;
    addr_d       = sram_addr;
    wdata_d      = sram_wdata;
    pop_c        = 1'b0;
    emit_c       = 1'b0;
    start_take_c = 1'b0;
    in_ready_d   = in_ready;

    // An idle FSM issues the first word on the same edge it leaves IDLE.
    // This keeps the accept-to-first-write latency at one cycle.
    case (state_q)
      IDLE:    emit_c = (fifo_cnt_q != 2'd0);
      WRITE:   emit_c = 1'b1;
      default: emit_c = 1'b0;
    endcase

    if (emit_c) begin
      wen_d   = 1'b0;
      addr_d  = addr_c;
      wdata_d = pack_c;
      if (word_cnt_q == WCW'(WORDS - 1)) begin
        pop_c      = 1'b1;
        word_cnt_d = '0;
        if (row_cnt_q == RCW'(NUM_ROWS - 1)) begin
          row_cnt_d = '0;
          if (busy) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end else begin
          row_cnt_d = row_cnt_q + RCW'(1);
        end
      end else begin
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end

    if (push_c && !pop_c)      fifo_cnt_d = fifo_cnt_q + 2'd1;
    else if (pop_c && !push_c) fifo_cnt_d = fifo_cnt_q - 2'd1;
    in_ready_d = (fifo_cnt_d != 2'd2);

    state_d = (fifo_cnt_d != 2'd0) ? WRITE : IDLE;

    // If start arrives on the done edge, it opens the next tile.
    start_take_c = start && (!busy || done_d);
    if (start_take_c) begin
      base_d    = cfg_base_addr;
      row_cnt_d = '0;
      busy_d    = 1'b1;
    end
  end

  // State, counters, FIFO pointers and outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      base_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      in_ready   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      base_q     <= base_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push_c) wr_ptr_q <= ~wr_ptr_q;
      if (pop_c)  rd_ptr_q <= ~rd_ptr_q;
      in_ready   <= in_ready_d;
      sram_wen   <= wen_d;
      sram_addr  <= addr_d;
      sram_wdata <= wdata_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Row storage. Its contents do not need a reset because the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= in_data;
  end

endmodule
